johnson_phase_decoder: RTL
==========================

# johnson_phase_decoder

Receive-side counterpart of the Johnson-counter latch-enable generator. Takes a WIDTH-bit Johnson code stream (sequence 0000→1000→1100→1110→1111→0111→0011→0001→0000 for WIDTH=4), checks legality, decodes it to a binary phase index and tracks sequence lock with a HUNT/LOCKED state machine. Sits beside any block that consumes a Johnson-counter phase, such as a latch-enable generator or a sampled data path, to monitor counter health and to regenerate the sampling strobe.

## Interface
- WIDTH, 4, Johnson code width; 2*WIDTH phases; must be ≥2
- LOCK_CNT, 3, consecutive in-sequence codes needed to lock; must be ≥1
- LOSS_CNT, 2, consecutive bad codes needed to drop lock; must be ≥1
- IW, $clog2(2*WIDTH), index width (localparam)
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- code_in  in  WIDTH  Johnson code sample
- code_valid  in  1  code_in is valid this cycle
- index_out  out  IW  decoded phase index, 0..2*WIDTH-1
- index_valid  out  1  1-cycle pulse: index_out is updated from a legal code
- illegal  out  1  1-cycle pulse: the valid code was not a Johnson code
- seq_err  out  1  1-cycle pulse: a sequence or legality error occurred while LOCKED
- sample_phase  out  1  1-cycle pulse: a legal code decoded to index 0 or WIDTH (the latch-enable phase)
- locked  out  1  level: state is LOCKED
- err_cnt  out  8  saturating count of seq_err pulses

## Operation
- Legal code: at most one transition between adjacent bits, i.e. 1…10…0 or 0…01…1.
- Decode, p = popcount(code): index = p if code[WIDTH-1]=1 or code=0; otherwise index = 2*WIDTH−p. Examples: 0111→5, 0001→7.
- expected is registered, IW wide, and increments modulo 2*WIDTH.
- Cycles with code_valid=0 change nothing. All pulses are low, and index_out and state hold.
- Illegal valid code: illegal=1, index_valid=0, index_out holds.
- HUNT:
  - Legal code equal to expected with run>0: run++.
  - Any other legal code: run=1.
  - In both cases expected ← index+1.
  - Illegal code: run=0.
  - When run reaches LOCK_CNT: go to LOCKED, clear miss.
  - No seq_err and no err_cnt change in HUNT.
- LOCKED:
  - Legal code equal to expected: miss=0.
  - Otherwise: seq_err=1, err_cnt+1 (saturating at 255), miss++.
  - expected increments on every valid code (freewheel).
  - When miss reaches LOSS_CNT: go to HUNT, run=0.
- sample_phase needs only legality. It does not depend on the lock state.

## Timing
- Reset values: index_out=0, index_valid=0, illegal=0, seq_err=0, sample_phase=0, locked=0, err_cnt=0; state=HUNT, expected=0, run=0, miss=0.
- Latency: code sampled on edge N gives all outputs after edge N, valid during cycle N+1.
- locked rises in the same cycle as the index_valid of the LOCK_CNT-th in-sequence code.
- locked falls in the same cycle as the seq_err of the LOSS_CNT-th consecutive bad code.
- Wrap: index 2*WIDTH−1 followed by 0 is in sequence, with no error.
- Reset asserted mid-operation clears everything immediately. err_cnt is not preserved.

## Configuration
- JDEC_ERRCNT_EN defined: err_cnt counts as specified.
- JDEC_ERRCNT_EN undefined: the err_cnt register is not built and the port is tied to 0. All other behaviour is unchanged.

## Structure
- Package jdec_pkg holds:
  - state enum {HUNT, LOCKED}
  - the ERR_CNT_W=8 constant
  - a function computing the default IW
- Sub-module johnson_code_decode: purely combinational, outputs legal and index from code_in, parameter WIDTH.
- Top level holds the FSM, run/miss counters, expected register and output registers.

## Test plan
All scenarios use WIDTH=4, LOCK_CNT=3, LOSS_CNT=2.
- Reset, then valid 0000, 1000, 1100 → index 0, 1, 2 with index_valid each cycle; sample_phase on 0000 only; locked=1 in the cycle after 1100.
- Locked, drive 16 consecutive codes through the wrap 0001→0000 → no seq_err; sample_phase on every 0000 and 1111.
- Locked, drive 1010 → illegal=1, seq_err=1, index_valid=0, err_cnt=1; a following correct code keeps locked=1 and clears miss.
- Locked at index 2, drive 0011, 0011 → seq_err twice, err_cnt=2, locked=0 after the second; then 3 in-sequence codes relock.
- code_valid low for 5 cycles mid-lock → outputs hold, no pulses; resuming with the expected code gives no error.
- rst_n pulsed low mid-lock → all outputs 0 immediately and state HUNT; without JDEC_ERRCNT_EN, err_cnt stays 0 throughout scenario 4.

Source files
------------

// File: rtl/jdec_pkg.sv
// Shared types and constants for the Johnson phase decoder.
// Optional err_cnt register is built only when JDEC_ERRCNT_EN is defined.
package jdec_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int ERR_CNT_W = 8;

    // Index width needed to number all 2*WIDTH phases of a WIDTH-bit Johnson code.
    function automatic int calc_iw(input int width);
        return $clog2(2 * width);
    endfunction

endpackage

// File: rtl/johnson_code_decode.sv
// Combinational Johnson code legality check and phase-index decode.
module johnson_code_decode
    import jdec_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]                code,
    output logic                            legal,
    output logic [calc_iw(WIDTH)-1:0]       index
);

    localparam int IW = calc_iw(WIDTH);
    localparam logic [IW:0] PHASES = (IW + 1)'(2 * WIDTH);

    logic [WIDTH-2:0] edges;
    logic [IW:0]      ones;
    logic [IW:0]      diff;

    // A Johnson code has at most one transition between adjacent bits.
    assign edges = code[WIDTH-1:1] ^ code[WIDTH-2:0];
    assign legal = ($countones(edges) <= 1);

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred,
        // and combinational logic uses blocking '=' so later lines see updated values.
        ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + {{IW{1'b0}}, code[i]};
        end
        diff = PHASES - ones;
        if (code[WIDTH-1] || (code == '0)) begin
            index = ones[IW-1:0];
        end else begin
            index = diff[IW-1:0];
        end
    end

endmodule

// File: rtl/johnson_phase_decoder.sv
// Johnson code monitor: decodes phase, tracks HUNT/LOCKED sequence lock, flags errors.
// Define JDEC_ERRCNT_EN to build the saturating err_cnt register; otherwise err_cnt is 0.
module johnson_phase_decoder
    import jdec_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              code_in,
    input  logic                          code_valid,
    output logic [calc_iw(WIDTH)-1:0]     index_out,
    output logic                          index_valid,
    output logic                          illegal,
    output logic                          seq_err,
    output logic                          sample_phase,
    output logic                          locked,
    output logic [ERR_CNT_W-1:0]          err_cnt
);

    localparam int IW     = calc_iw(WIDTH);
    localparam int RUN_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);
    localparam logic [IW-1:0]     LAST_IDX = IW'(2 * WIDTH - 1);
    localparam logic [IW-1:0]     HALF_IDX = IW'(WIDTH);
    localparam logic [RUN_W-1:0]  RUN_LOCK = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(LOSS_CNT);

    state_t            state, state_n;
    logic [IW-1:0]     expected, expected_n;
    logic [RUN_W-1:0]  run, run_n;
    logic [MISS_W-1:0] miss, miss_n;
    logic [IW-1:0]     index_n;
    logic              index_valid_n, illegal_n, seq_err_n, sample_n;
    logic              legal;
    logic [IW-1:0]     index;

    johnson_code_decode #(.WIDTH(WIDTH)) u_decode (
        .code  (code_in),
        .legal (legal),
        .index (index)
    );

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == LAST_IDX) ? '0 : i + 1'b1;
    endfunction

    always_comb begin
        state_n       = state;
        expected_n    = expected;
        run_n         = run;
        miss_n        = miss;
        index_n       = index_out;
        index_valid_n = 1'b0;
        illegal_n     = 1'b0;
        seq_err_n     = 1'b0;
        sample_n      = 1'b0;
        if (code_valid) begin
            illegal_n = !legal;
            if (legal) begin
                index_n       = index;
                index_valid_n = 1'b1;
                sample_n      = (index == '0) || (index == HALF_IDX);
            end
            if (state == HUNT) begin
                if (legal) begin
                    expected_n = next_idx(index);
                    if ((index == expected) && (run != '0)) begin
                        run_n = run + 1'b1;
                    end else begin
                        run_n = RUN_W'(1);
                    end
                    if (run_n == RUN_LOCK) begin
                        state_n = LOCKED;
                        miss_n  = '0;
                    end
                end else begin
                    run_n = '0;
                end
            end else begin
                // Expected phase freewheels while locked, so a single glitch does not shift it.
                expected_n = next_idx(expected);
                if (legal && (index == expected)) begin
                    miss_n = '0;
                end else begin
                    seq_err_n = 1'b1;
                    miss_n    = miss + 1'b1;
                    if (miss_n == MISS_MAX) begin
                        state_n = HUNT;
                        run_n   = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking '<=' so all registers update together.
        if (!rst_n) begin
            state        <= HUNT;
            expected     <= '0;
            run          <= '0;
            miss         <= '0;
            index_out    <= '0;
            index_valid  <= 1'b0;
            illegal      <= 1'b0;
            seq_err      <= 1'b0;
            sample_phase <= 1'b0;
        end else begin
            state        <= state_n;
            expected     <= expected_n;
            run          <= run_n;
            miss         <= miss_n;
            index_out    <= index_n;
            index_valid  <= index_valid_n;
            illegal      <= illegal_n;
            seq_err      <= seq_err_n;
            sample_phase <= sample_n;
        end
    end

    assign locked = (state == LOCKED);

`ifdef JDEC_ERRCNT_EN
    logic [ERR_CNT_W-1:0] err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= '0;
        end else if (seq_err_n && (err_q != '1)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule
